pixel_row_readout: RTL
======================

Name: pixel_row_readout

Overview:
- Digital controller for one row of PIXEL_ARRAY_WIDTH pixel sensors.
- Sequences erase, expose and ramp conversion for the row.
- Latches a per-pixel digital code from each pixel's comparator output during the ramp.
- Serialises the row codes to the downstream frame buffer over a valid/ready handshake.
- Sits between the pixel row and the readout bus. It replaces free-running shared COUNTER/READ strobes with an owned, clocked row sequence.

Parameters:
- PIXEL_ARRAY_WIDTH, 2: pixels in the row (>=1).
- COUNTER_BITS, 8: code width; conversion ramp lasts 2**COUNTER_BITS cycles.
- ERASE_CYCLES, 4: cycles ERASE is held (>=1).
- EXPOSE_CYCLES, 255: cycles EXPOSE is held (>=1).
- IDX_BITS, max(1, clog2(PIXEL_ARRAY_WIDTH)): derived, width of PIXEL_IDX.

Ports:
- CLK, in, 1: system clock; all logic on rising edge.
- RESET, in, 1: synchronous, active-high reset.
- START, in, 1: request one row cycle; sampled only in IDLE.
- COMP, in, PIXEL_ARRAY_WIDTH: per-pixel comparator outputs, synchronous to CLK; bit i high once the ramp passes pixel i's voltage.
- DATA_READY, in, 1: downstream accepts DATA_OUT.
- ERASE, out, 1: pixel erase strobe.
- EXPOSE, out, 1: pixel expose strobe.
- CONVERT, out, 1: ramp enable to the analog ramp generator.
- COUNTER, out, COUNTER_BITS: current ramp code.
- DATA_OUT, out, COUNTER_BITS: code of pixel PIXEL_IDX.
- DATA_VALID, out, 1: DATA_OUT/PIXEL_IDX valid.
- PIXEL_IDX, out, IDX_BITS: index of the pixel on DATA_OUT.
- BUSY, out, 1: high in every state except IDLE.
- ROW_DONE, out, 1: one-cycle pulse after the last pixel transfers.

Behaviour:
- Reset (RESET high at an edge): state is IDLE. All outputs are 0, codes are cleared, latched flags are cleared. This applies mid-operation too: the current row is dropped and no ROW_DONE is issued.
- FSM states are IDLE, ERASE, EXPOSE, CONV, READOUT. All outputs are registered.
- IDLE: START=1 at edge 0 enters ERASE. START is ignored in all other states.
- ERASE: ERASE=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: EXPOSE=1 for exactly EXPOSE_CYCLES cycles, then CONV.
- CONV: CONVERT=1 for exactly 2**COUNTER_BITS cycles. COUNTER is 0 in the first CONV cycle and increments by 1 each cycle up to all-ones. It never wraps inside CONV.
- Code capture in CONV: if COMP[i]=1 in a cycle where pixel i is not yet latched, code[i] takes the COUNTER value of that cycle and pixel i is marked latched. Later COMP activity on that pixel is ignored, so the first crossing wins. COMP may be high in the first CONV cycle, giving code 0.
- Multiple pixels may latch in the same cycle.
- After the all-ones cycle, every unlatched pixel's code becomes all-ones (saturation). The FSM then enters READOUT and COUNTER returns to 0.
- READOUT: DATA_VALID=1, PIXEL_IDX=idx, DATA_OUT=code[idx], with idx starting at 0.
  - A transfer happens on an edge where DATA_VALID and DATA_READY are both high. idx then increments.
  - DATA_OUT and PIXEL_IDX are stable while DATA_READY=0.
  - With DATA_READY held high, one pixel transfers per cycle.
- Transfer of pixel PIXEL_ARRAY_WIDTH-1 moves the FSM to IDLE. On that same edge DATA_VALID drops and ROW_DONE=1 for that single IDLE cycle.
- START high during that ROW_DONE cycle starts a new row at the next edge; back-to-back rows are allowed.
- Codes and latched flags are cleared on entry to ERASE.
- Latency for an uninterrupted row: START at edge 0 puts the first DATA_VALID in cycle ERASE_CYCLES+EXPOSE_CYCLES+2**COUNTER_BITS+1.
- BUSY=1 from ERASE entry until the last transfer edge.
- ERASE, EXPOSE and CONVERT are mutually exclusive.

Test Plan:
- W=4, B=8, E=3, X=10, READY=1; START at cycle 0. Required: ERASE high cycles 1-3, EXPOSE high 4-13, CONVERT high 14-269. COMP bits rise at COUNTER=0,17,200,255, giving DATA_OUT 0,17,200,255 on cycles 270-273 with PIXEL_IDX 0-3. ROW_DONE in cycle 274.
- Same setup, COMP[2] never rises and COMP[1] rises at 50, falls at 60, rises at 90. Required: codes are 0,50,255,255.
- Readout backpressure: DATA_READY toggles 1,0,0,1 from READOUT entry. Required: pixel 0 transfers first, then DATA_OUT=code[1] with PIXEL_IDX=1 is held for 3 cycles, and all 4 codes arrive in order with none dropped or duplicated.
- START pulsed during EXPOSE, and again during the ROW_DONE cycle. Required: the first pulse is ignored; the second starts a new row with ERASE next cycle and the codes cleared.
- RESET asserted in CONV at COUNTER=100. Required: the next cycle has all outputs 0, BUSY=0 and no ROW_DONE. A fresh START then gives correct codes.
- PIXEL_ARRAY_WIDTH=1, B=4: the ramp lasts 16 cycles, PIXEL_IDX is 1 bit and stays 0, and ROW_DONE follows the single transfer.

Source files
------------

// File: rtl/pixel_row_readout.sv
`timescale 1ns/1ps
// pixel_row_readout: owns the erase/expose/ramp sequence for one pixel row,
// latches each pixel's first comparator crossing as its code, then streams
// the row codes out over a valid/ready handshake.
module pixel_row_readout #(
  parameter int PIXEL_ARRAY_WIDTH = 2,
  parameter int COUNTER_BITS      = 8,
  parameter int ERASE_CYCLES      = 4,
  parameter int EXPOSE_CYCLES     = 255,
  localparam int IDX_BITS = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         START,
  input  logic [PIXEL_ARRAY_WIDTH-1:0] COMP,
  input  logic                         DATA_READY,
  output logic                         ERASE,
  output logic                         EXPOSE,
  output logic                         CONVERT,
  output logic [COUNTER_BITS-1:0]      COUNTER,
  output logic [COUNTER_BITS-1:0]      DATA_OUT,
  output logic                         DATA_VALID,
  output logic [IDX_BITS-1:0]          PIXEL_IDX,
  output logic                         BUSY,
  output logic                         ROW_DONE
);

  localparam int TMAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(PIXEL_ARRAY_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONV,
    S_READOUT
  } state_t;

  state_t                       state_q, state_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic [COUNTER_BITS-1:0]      counter_q, counter_d;
  logic [IDX_BITS-1:0]          idx_q, idx_d;
  logic [COUNTER_BITS-1:0]      code_q [PIXEL_ARRAY_WIDTH];
  logic [COUNTER_BITS-1:0]      code_d [PIXEL_ARRAY_WIDTH];
  logic [PIXEL_ARRAY_WIDTH-1:0] latched_q, latched_d;
  logic                         row_done_d;
  logic [COUNTER_BITS-1:0]      dout_d;

  logic                         erase_q, expose_q, convert_q, valid_q, busy_q, row_done_q;
  logic [COUNTER_BITS-1:0]      dout_q;
  logic [IDX_BITS-1:0]          pidx_q;

  // Next-state logic: phase timing, ramp count, first-crossing capture, readout index.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    counter_d  = counter_q;
    idx_d      = idx_q;
    code_d     = code_q;
    latched_d  = latched_q;
    row_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d   = S_ERASE;
          timer_d   = TW'(ERASE_CYCLES - 1);
          idx_d     = '0;
          latched_d = '0;
          for (int unsigned i = 0; i < PIXEL_ARRAY_WIDTH; i++) code_d[i] = '0;
        end
      end
      S_ERASE: begin
        if (timer_q == '0) begin
          state_d = S_EXPOSE;
          timer_d = TW'(EXPOSE_CYCLES - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_EXPOSE: begin
        if (timer_q == '0) begin
          state_d   = S_CONV;
          counter_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_CONV: begin
        // The all-ones cycle doubles as saturation: any pixel still unlatched takes that code.
        for (int unsigned i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
          if (!latched_q[i] && (COMP[i] || (counter_q == '1))) begin
            code_d[i]    = counter_q;
            latched_d[i] = 1'b1;
          end
        end
        if (counter_q == '1) begin
          state_d   = S_READOUT;
          counter_d = '0;
          idx_d     = '0;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      S_READOUT: begin
        if (DATA_READY) begin
          if (idx_q == LAST_IDX) begin
            state_d    = S_IDLE;
            row_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Select the code that will be presented on the bus next cycle.
  always_comb begin
    dout_d = '0;
    for (int unsigned i = 0; i < PIXEL_ARRAY_WIDTH; i++) begin
      if (idx_d == IDX_BITS'(i)) dout_d = code_d[i];
    end
  end

  // State and output registers; outputs decode the next state so they change on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      counter_q  <= '0;
      idx_q      <= '0;
      latched_q  <= '0;
      for (int unsigned i = 0; i < PIXEL_ARRAY_WIDTH; i++) code_q[i] <= '0;
      erase_q    <= 1'b0;
      expose_q   <= 1'b0;
      convert_q  <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      row_done_q <= 1'b0;
      dout_q     <= '0;
      pidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      counter_q  <= counter_d;
      idx_q      <= idx_d;
      latched_q  <= latched_d;
      for (int unsigned i = 0; i < PIXEL_ARRAY_WIDTH; i++) code_q[i] <= code_d[i];
      erase_q    <= (state_d == S_ERASE);
      expose_q   <= (state_d == S_EXPOSE);
      convert_q  <= (state_d == S_CONV);
      valid_q    <= (state_d == S_READOUT);
      busy_q     <= (state_d != S_IDLE);
      row_done_q <= row_done_d;
      dout_q     <= (state_d == S_READOUT) ? dout_d : '0;
      pidx_q     <= (state_d == S_READOUT) ? idx_d : '0;
    end
  end

  assign ERASE      = erase_q;
  assign EXPOSE     = expose_q;
  assign CONVERT    = convert_q;
  assign COUNTER    = counter_q;
  assign DATA_OUT   = dout_q;
  assign DATA_VALID = valid_q;
  assign PIXEL_IDX  = pidx_q;
  assign BUSY       = busy_q;
  assign ROW_DONE   = row_done_q;

endmodule
